uart_tx_piso: RTL and testbench

Parallel-in/serial-out transmit stage of the UART Tx path, directly downstream of the frame generator. Accepts an 11-bit frame (start, data, parity, stop/idle bits) on a valid/ready handshake, latches it, and shifts it onto the serial line LSB first, one bit per baud tick. Reports busy and end-of-frame status to the Tx controller. Optionally generates a line break.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_piso.sv | 129 ++++++++++++
 tb/tb_uart_tx_piso.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, default geometry and line levels.
// The break generator is compiled in only when UART_TX_BREAK_EN is defined.
package uart_pkg;

   localparam int unsigned FrameWDefault     = 11;
   localparam int unsigned BreakTicksDefault = 22;
   localparam logic        LineIdle          = 1'b1;

   typedef enum logic [1:0] {
      StIdle,
      StSync,
      StShift,
      StBreak
   } tx_state_e;

endpackage

// File: rtl/uart_tx_piso.sv
// UART transmit shifter: latches a pre-built frame and shifts it out LSB first, one bit per baud
// tick. Line-break generation is compiled in only when UART_TX_BREAK_EN is defined.
module uart_tx_piso
   import uart_pkg::*;
#(
   parameter int unsigned FrameW     = FrameWDefault,
   parameter int unsigned BreakTicks = BreakTicksDefault
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              baud_tick_i,
   input  logic [FrameW-1:0] frame_i,
   input  logic              send_i,
   input  logic              break_req_i,
   output logic              ready_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              tx_o
);

   localparam int unsigned CntW = $clog2(FrameW + 1);

   tx_state_e         state_q;
   logic [FrameW-1:0] shreg_q;
   logic [CntW-1:0]   cnt_q;
   logic              tx_q;
   logic              ready_q;
   logic              busy_q;
   logic              done_q;

`ifdef UART_TX_BREAK_EN
   localparam int unsigned BrkW = $clog2(BreakTicks + 1);

   logic [BrkW-1:0] brk_cnt_q;
   logic            brk_min_met;

   // The count has reached the minimum once this tick is included.
   assign brk_min_met = (brk_cnt_q >= BrkW'(BreakTicks - 1));
`else
   logic unused_break_req;
   assign unused_break_req = break_req_i;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         shreg_q   <= '1;
         cnt_q     <= '0;
         tx_q      <= LineIdle;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef UART_TX_BREAK_EN
         brk_cnt_q <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (send_i) begin
                  shreg_q <= frame_i;
                  cnt_q   <= '0;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= StSync;
               end
`ifdef UART_TX_BREAK_EN
               else if (break_req_i) begin
                  brk_cnt_q <= '0;
                  tx_q      <= ~LineIdle;
                  ready_q   <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= StBreak;
               end
`endif
            end
            StSync: begin
               // A tick coincident with acceptance is not seen here, so bit 0 waits a full period.
               if (baud_tick_i) begin
                  tx_q    <= shreg_q[0];
                  state_q <= StShift;
               end
            end
            StShift: begin
               if (baud_tick_i) begin
                  if (cnt_q == CntW'(FrameW - 1)) begin
                     tx_q    <= LineIdle;
                     done_q  <= 1'b1;
                     ready_q <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= StIdle;
                  end else begin
                     cnt_q   <= cnt_q + 1'b1;
                     shreg_q <= {LineIdle, shreg_q[FrameW-1:1]};
                     tx_q    <= shreg_q[1];
                  end
               end
            end
`ifdef UART_TX_BREAK_EN
            StBreak: begin
               if (baud_tick_i) begin
                  if (brk_cnt_q != BrkW'(BreakTicks)) begin
                     brk_cnt_q <= brk_cnt_q + 1'b1;
                  end
                  if (!break_req_i && brk_min_met) begin
                     tx_q    <= LineIdle;
                     ready_q <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= StIdle;
                  end
               end
            end
`endif
            default: begin
               tx_q    <= LineIdle;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign ready_o = ready_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;
   assign tx_o    = tx_q;

endmodule

// File: tb/tb_uart_tx_piso.sv
// Self-checking bench for uart_tx_piso: directed scenarios plus random traffic against a
// tick-counting reference model. Break scenarios follow UART_TX_BREAK_EN.
module tb_uart_tx_piso;
   import uart_pkg::*;

   localparam int unsigned FrameW     = FrameWDefault;
   localparam int unsigned BreakTicks = BreakTicksDefault;

   logic              clk       = 1'b0;
   logic              rst_n     = 1'b0;
   logic              baud_tick = 1'b0;
   logic              send      = 1'b0;
   logic              break_req = 1'b0;
   logic [FrameW-1:0] frame_in  = '1;
   logic              ready, busy, done, tx;

   uart_tx_piso dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .baud_tick_i (baud_tick),
      .frame_i     (frame_in),
      .send_i      (send),
      .break_req_i (break_req),
      .ready_o     (ready),
      .busy_o      (busy),
      .done_o      (done),
      .tx_o        (tx)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: a frame is "ticks seen since acceptance"; tick k (1..FrameW) starts bit k-1,
   // tick FrameW+1 ends the frame.
   bit                m_active = 0;
   int                m_ticks  = 0;
   logic [FrameW-1:0] m_frame  = '1;
   bit                m_brk    = 0;
   int                m_brk_n  = 0;
   logic              e_tx = 1'b1, e_ready = 1'b1, e_busy = 1'b0, e_done = 1'b0;

   int done_seen  = 0;
   int tick_div   = 16;
   int tick_phase = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      if (!rst_n) begin
         m_active = 0;
         m_brk    = 0;
         e_tx     = 1'b1;
         e_ready  = 1'b1;
         e_busy   = 1'b0;
         e_done   = 1'b0;
         return;
      end
      e_done = 1'b0;
      if (m_brk) begin
         if (baud_tick) begin
            m_brk_n++;
            if (!break_req && m_brk_n >= BreakTicks) begin
               m_brk   = 0;
               e_tx    = 1'b1;
               e_ready = 1'b1;
               e_busy  = 1'b0;
            end
         end
      end else if (m_active) begin
         if (baud_tick) begin
            m_ticks++;
            if (m_ticks == FrameW + 1) begin
               m_active = 0;
               e_done   = 1'b1;
               e_tx     = 1'b1;
               e_ready  = 1'b1;
               e_busy   = 1'b0;
            end else begin
               e_tx = m_frame[m_ticks-1];
            end
         end
      end else if (send) begin
         m_active = 1;
         m_ticks  = 0;
         m_frame  = frame_in;
         e_ready  = 1'b0;
         e_busy   = 1'b1;
      end
`ifdef UART_TX_BREAK_EN
      else if (break_req) begin
         m_brk   = 1;
         m_brk_n = 0;
         e_tx    = 1'b0;
         e_ready = 1'b0;
         e_busy  = 1'b1;
      end
`endif
   endtask

   // One clock: derive the tick, advance the model, clock the DUT, compare away from the edge.
   task automatic cycle(input string tag);
      baud_tick  = (tick_phase >= tick_div - 1);
      tick_phase = baud_tick ? 0 : tick_phase + 1;
      model_step();
      @(posedge clk);
      #1;
      check_eq({tag, "_tx"},    tx,    e_tx);
      check_eq({tag, "_ready"}, ready, e_ready);
      check_eq({tag, "_busy"},  busy,  e_busy);
      check_eq({tag, "_done"},  done,  e_done);
      if (done) done_seen++;
   endtask

   task automatic run_until_done(input string tag, input int target, input int limit);
      for (int i = 0; i < limit && done_seen < target; i++) cycle(tag);
   endtask

   initial begin
      // Reset held, then idle line for 50 ticks.
      rst_n = 1'b0;
      repeat (4) cycle("rst");
      check_eq("rst_tx", tx, 1'b1);
      check_eq("rst_ready", ready, 1'b1);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_done", done, 1'b0);
      rst_n = 1'b1;
      repeat (50 * 16) cycle("idle");

      // Single frame, 16 CLK per bit.
      done_seen = 0;
      frame_in  = 11'b11010101010;
      send      = 1'b1;
      cycle("f1");
      send      = 1'b0;
      frame_in  = FrameW'($urandom);
      run_until_done("f1", 1, 400);
      repeat (20) cycle("f1");
      check_eq("f1_done_count", done_seen, 1);

      // Send during SHIFT with another frame must be ignored.
      done_seen = 0;
      frame_in  = 11'h2B5;
      send      = 1'b1;
      cycle("ign");
      send      = 1'b0;
      repeat (5 * 16) cycle("ign");
      frame_in  = 11'h14A;
      send      = 1'b1;
      repeat (20) cycle("ign");
      send      = 1'b0;
      run_until_done("ign", 1, 400);
      repeat (20) cycle("ign");
      check_eq("ign_done_count", done_seen, 1);

      // Send held across two frames; second accepted in the Done cycle.
      done_seen = 0;
      frame_in  = 11'h7FE;
      send      = 1'b1;
      cycle("b2b");
      frame_in  = 11'h001;
      run_until_done("b2b", 1, 400);
      cycle("b2b");
      check_eq("b2b_second_accepted", busy, 1'b1);
      send      = 1'b0;
      run_until_done("b2b", 2, 400);
      repeat (20) cycle("b2b");
      check_eq("b2b_done_count", done_seen, 2);

      // Reset after the 5th bit aborts the frame; a following frame goes out whole.
      done_seen = 0;
      frame_in  = 11'h555;
      send      = 1'b1;
      cycle("abort");
      send      = 1'b0;
      for (int i = 0; i < 400 && !(m_active && m_ticks == 6); i++) cycle("abort");
      rst_n = 1'b0;
      cycle("abort");
      check_eq("abort_tx", tx, 1'b1);
      check_eq("abort_ready", ready, 1'b1);
      rst_n = 1'b1;
      repeat (16 * 14) cycle("abort");
      check_eq("abort_no_done", done_seen, 0);
      frame_in = 11'h3C3;
      send     = 1'b1;
      cycle("abort");
      send     = 1'b0;
      run_until_done("abort", 1, 400);
      repeat (20) cycle("abort");
      check_eq("abort_refill_done", done_seen, 1);

      // Break request: 30 ticks long, then 5 ticks short (ignored when the feature is absent).
      break_req = 1'b1;
      repeat (30 * 16) cycle("brk_long");
      break_req = 1'b0;
      repeat (30 * 16) cycle("brk_long");
      break_req = 1'b1;
      repeat (5 * 16) cycle("brk_short");
      break_req = 1'b0;
      repeat (30 * 16) cycle("brk_short");
      check_eq("brk_ready_after", ready, 1'b1);
      check_eq("brk_tx_after", tx, 1'b1);

      // Random traffic with varying tick rates.
      for (int seg = 0; seg < 20; seg++) begin
         tick_div = $urandom_range(1, 8);
         for (int i = 0; i < 200; i++) begin
            send      = ($urandom_range(0, 3) == 0);
            frame_in  = FrameW'($urandom);
            break_req = ($urandom_range(0, 15) == 0);
            rst_n     = ($urandom_range(0, 99) != 0);
            cycle("rand");
         end
      end
      send      = 1'b0;
      break_req = 1'b0;
      rst_n     = 1'b1;
      repeat (200) cycle("drain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
